// File: rtl/common_pkg.sv
// Shared types and sizing constants for the matrix datapath.
// Also holds the skew feeder's state encoding and flush length.
package common_pkg;

  localparam int SYS_ARRAY_SIZE = 4;
  localparam int MATRIX_DATA_W  = 16;

  typedef logic [MATRIX_DATA_W-1:0] matrix_data_t;

  // Zeros needed after the last slice for it to reach PE(N-1,N-1).
  localparam int FEED_FLUSH_CYCLES = 2*SYS_ARRAY_SIZE-1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } feeder_state_t;

endpackage

// File: rtl/skew_lane.sv
// Fixed-depth shift register for one operand lane of the systolic feeder.
// Lane i of the array uses depth i+1 to build the diagonal wavefront.
module skew_lane
  import common_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  matrix_data_t shift_data,
  output matrix_data_t lane_data
);

  matrix_data_t stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= shift_data;
      for (int s = 1; s < DEPTH; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign lane_data = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Operand skew stage in front of the N x N systolic array: accepts one
// K-slice per beat, skews lane i by i cycles, flushes zeros and flags done.
module systolic_feeder
  import common_pkg::*;
#(
  parameter int K_MAX = 1024
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      valid_i,
  output logic                                      ready_o,
  input  logic                                      last_i,
  input  matrix_data_t [SYS_ARRAY_SIZE-1:0]         a_col_i,
  input  matrix_data_t [SYS_ARRAY_SIZE-1:0]         b_row_i,
  output matrix_data_t [SYS_ARRAY_SIZE-1:0]         a_o,
  output matrix_data_t [SYS_ARRAY_SIZE-1:0]         b_o,
  output logic                                      busy_o,
  output logic                                      done_o,
  output logic [$clog2(K_MAX+1)-1:0]                k_cnt_o,
  output logic                                      err_o
);

  localparam int N  = SYS_ARRAY_SIZE;
  localparam int KW = $clog2(K_MAX+1);
  localparam int FW = $clog2(FEED_FLUSH_CYCLES+1);

  feeder_state_t            state_q, state_d;
  logic [FW-1:0]            flush_cnt_q;
  logic [KW-1:0]            k_cnt_q;
  logic                     err_q;
  logic                     accept;
  logic                     flush_last;
  matrix_data_t [N-1:0]     a_shift, b_shift;

  assign accept     = valid_i && ready_o;
  assign flush_last = (flush_cnt_q == FW'(FEED_FLUSH_CYCLES-1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_d = last_i ? FLUSH : STREAM;
      end
      STREAM: begin
        ready_o = 1'b1;
        busy_o  = 1'b1;
        if (valid_i && last_i) state_d = FLUSH;
      end
      FLUSH: begin
        busy_o = 1'b1;
        if (flush_last) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                flush_cnt_q <= '0;
    else if (state_q == FLUSH) flush_cnt_q <= flush_cnt_q + FW'(1);
    else                       flush_cnt_q <= '0;
  end

  // Beat count saturates; an accept at saturation still feeds data but latches err.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      k_cnt_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == DONE)                          k_cnt_q <= '0;
      else if (accept && (k_cnt_q != KW'(K_MAX)))   k_cnt_q <= k_cnt_q + KW'(1);
      if (accept && (k_cnt_q == KW'(K_MAX)))        err_q   <= 1'b1;
    end
  end

  assign k_cnt_o = k_cnt_q;
  assign err_o   = err_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_shift[i] = accept ? a_col_i[i] : '0;
      b_shift[i] = accept ? b_row_i[i] : '0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_lane #(.DEPTH(i+1)) u_a_lane (
      .clk        (clk_i),
      .rst_n      (rst_i),
      .shift_data (a_shift[i]),
      .lane_data  (a_o[i])
    );
    skew_lane #(.DEPTH(i+1)) u_b_lane (
      .clk        (clk_i),
      .rst_n      (rst_i),
      .shift_data (b_shift[i]),
      .lane_data  (b_o[i])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=4): table-driven single-beat tile
// plus hand-written burst, bubble, backpressure, overflow and reset sequences.
module tb_systolic_feeder;
  import common_pkg::*;

  localparam int N   = SYS_ARRAY_SIZE;
  localparam int KW  = $clog2(1024+1);
  localparam int KW2 = $clog2(2+1);

  typedef matrix_data_t [N-1:0] lanes_t;

  typedef struct {
    logic   valid;
    logic   last;
    lanes_t a;
    lanes_t b;
    logic   exp_ready;
    logic   exp_busy;
    logic   exp_done;
    int     exp_k;
    lanes_t exp_a;
    lanes_t exp_b;
  } vec_t;

  logic clk = 1'b0;
  logic rst_i, valid_i, last_i;
  lanes_t a_col_i, b_row_i;
  logic ready_o, busy_o, done_o, err_o;
  lanes_t a_o, b_o;
  logic [KW-1:0] k_cnt_o;
  logic ready_s, busy_s, done_s, err_s;
  lanes_t a_s, b_s;
  logic [KW2-1:0] k_cnt_s;

  always #5 clk = ~clk;

  systolic_feeder #(.K_MAX(1024)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .last_i(last_i),
    .a_col_i(a_col_i), .b_row_i(b_row_i), .a_o(a_o), .b_o(b_o), .busy_o(busy_o),
    .done_o(done_o), .k_cnt_o(k_cnt_o), .err_o(err_o)
  );

  systolic_feeder #(.K_MAX(2)) dut_small (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_s), .last_i(last_i),
    .a_col_i(a_col_i), .b_row_i(b_row_i), .a_o(a_s), .b_o(b_s), .busy_o(busy_s),
    .done_o(done_s), .k_cnt_o(k_cnt_s), .err_o(err_s)
  );

  int errors = 0;
  int checks = 0;
  lanes_t in_hist_a[$], in_hist_b[$], out_hist_a[$], out_hist_b[$];

  function automatic matrix_data_t elem_a(int k, int i);
    return matrix_data_t'(10*(k+1) + i);
  endfunction

  function automatic matrix_data_t elem_b(int k, int j);
    return matrix_data_t'(100 + 10*k + j);
  endfunction

  function automatic lanes_t slice_a(int k);
    lanes_t s;
    for (int i = 0; i < N; i++) s[i] = elem_a(k, i);
    return s;
  endfunction

  function automatic lanes_t slice_b(int k);
    lanes_t s;
    for (int i = 0; i < N; i++) s[i] = elem_b(k, i);
    return s;
  endfunction

  function automatic lanes_t mk(int d3, int d2, int d1, int d0);
    return {matrix_data_t'(d3), matrix_data_t'(d2), matrix_data_t'(d1), matrix_data_t'(d0)};
  endfunction

  function automatic vec_t row(logic v, logic l, lanes_t a, lanes_t b, logic er,
                               logic eb, logic ed, int ek, lanes_t ea, lanes_t ebl);
    vec_t r;
    r.valid = v; r.last = l; r.a = a; r.b = b;
    r.exp_ready = er; r.exp_busy = eb; r.exp_done = ed; r.exp_k = ek;
    r.exp_a = ea; r.exp_b = ebl;
    return r;
  endfunction

  task automatic compare(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one beat, advance past the edge, log what the lanes now show.
  task automatic applyStimulus(input logic v, input logic l, input lanes_t a,
                               input lanes_t b, input bit acc);
    valid_i = v; last_i = l; a_col_i = a; b_row_i = b;
    in_hist_a.push_back(acc ? a : lanes_t'('0));
    in_hist_b.push_back(acc ? b : lanes_t'('0));
    @(posedge clk); #1;
    out_hist_a.push_back(a_o);
    out_hist_b.push_back(b_o);
  endtask

  // Lane i should show whatever entered stage 0 i edges before the latest one.
  task automatic checkOutput(string tag, logic er, logic eb, logic ed, int ek);
    lanes_t ea, ebl;
    for (int i = 0; i < N; i++) begin
      int idx = in_hist_a.size() - 1 - i;
      ea[i]  = (idx >= 0) ? in_hist_a[idx][i] : '0;
      ebl[i] = (idx >= 0) ? in_hist_b[idx][i] : '0;
    end
    compare({tag, ".a_o"},     a_o,     ea);
    compare({tag, ".b_o"},     b_o,     ebl);
    compare({tag, ".ready_o"}, ready_o, er);
    compare({tag, ".busy_o"},  busy_o,  eb);
    compare({tag, ".done_o"},  done_o,  ed);
    compare({tag, ".k_cnt_o"}, 64'(k_cnt_o), 64'(ek));
  endtask

  task automatic clear_model();
    in_hist_a.delete(); in_hist_b.delete();
    out_hist_a.delete(); out_hist_b.delete();
  endtask

  task automatic do_reset();
    rst_i = 1'b0; valid_i = 1'b0; last_i = 1'b0; a_col_i = '0; b_row_i = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl[9];
    longint acc_sum, acc_exp;
    int ci, cj;

    do_reset();
    checkOutput("reset", 1'b1, 1'b0, 1'b0, 0);
    compare("reset.err_o", err_o, 1'b0);

    // Single beat with last set: one diagonal of data, then flush and done in cycle 8.
    tbl[0] = row(1, 1, mk(4,3,2,1), mk(8,7,6,5), 0, 1, 0, 1, mk(0,0,0,1), mk(0,0,0,5));
    tbl[1] = row(0, 0, '0, '0, 0, 1, 0, 1, mk(0,0,2,0), mk(0,0,6,0));
    tbl[2] = row(0, 0, '0, '0, 0, 1, 0, 1, mk(0,3,0,0), mk(0,7,0,0));
    tbl[3] = row(0, 0, '0, '0, 0, 1, 0, 1, mk(4,0,0,0), mk(8,0,0,0));
    tbl[4] = row(0, 0, '0, '0, 0, 1, 0, 1, '0, '0);
    tbl[5] = row(0, 0, '0, '0, 0, 1, 0, 1, '0, '0);
    tbl[6] = row(0, 0, '0, '0, 0, 1, 0, 1, '0, '0);
    tbl[7] = row(0, 0, '0, '0, 0, 0, 1, 1, '0, '0);
    tbl[8] = row(0, 0, '0, '0, 1, 0, 0, 0, '0, '0);
    for (int r = 0; r < 9; r++) begin
      applyStimulus(tbl[r].valid, tbl[r].last, tbl[r].a, tbl[r].b, tbl[r].valid);
      compare($sformatf("single[%0d].a_o", r),     a_o,     tbl[r].exp_a);
      compare($sformatf("single[%0d].b_o", r),     b_o,     tbl[r].exp_b);
      compare($sformatf("single[%0d].ready_o", r), ready_o, tbl[r].exp_ready);
      compare($sformatf("single[%0d].busy_o", r),  busy_o,  tbl[r].exp_busy);
      compare($sformatf("single[%0d].done_o", r),  done_o,  tbl[r].exp_done);
      compare($sformatf("single[%0d].k_cnt_o", r), 64'(k_cnt_o), 64'(tbl[r].exp_k));
    end

    // Four back-to-back beats, last on k=3; done in cycle 11.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, logic'(k == 3), slice_a(k), slice_b(k), 1'b1);
      checkOutput($sformatf("burst.c%0d", k+1), logic'(k < 3), 1'b1, 1'b0, k+1);
    end
    compare("burst.a0_is_slice3", a_o[0], elem_a(3, 0));
    compare("burst.a3_is_slice0", a_o[3], elem_a(0, 3));
    for (int c = 5; c <= 10; c++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
      checkOutput($sformatf("burst.c%0d", c), 1'b0, 1'b1, 1'b0, 4);
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("burst.c11", 1'b0, 1'b0, 1'b1, 4);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("burst.c12", 1'b1, 1'b0, 1'b0, 0);

    // Bubble between two slices; accumulators must equal the two-slice dot products.
    do_reset();
    applyStimulus(1'b1, 1'b0, slice_a(0), slice_b(0), 1'b1);
    checkOutput("bubble.c1", 1'b1, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("bubble.c2", 1'b1, 1'b1, 1'b0, 1);
    compare("bubble.a0_gap", a_o[0], '0);
    applyStimulus(1'b1, 1'b1, slice_a(1), slice_b(1), 1'b1);
    checkOutput("bubble.c3", 1'b0, 1'b1, 1'b0, 2);
    compare("bubble.a0_slice1", a_o[0], elem_a(1, 0));
    for (int c = 4; c <= 9; c++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
      checkOutput($sformatf("bubble.c%0d", c), 1'b0, 1'b1, 1'b0, 2);
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("bubble.c10", 1'b0, 1'b0, 1'b1, 2);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc_sum = 0;
        for (int c = 0; c < out_hist_a.size(); c++) begin
          ci = c - j;
          cj = c - i;
          if (ci >= 0 && cj >= 0)
            acc_sum += longint'(out_hist_a[ci][i]) * longint'(out_hist_b[cj][j]);
        end
        acc_exp = longint'(elem_a(0, i)) * longint'(elem_b(0, j))
                + longint'(elem_a(1, i)) * longint'(elem_b(1, j));
        compare($sformatf("bubble.pe%0d%0d", i, j), 64'(acc_sum), 64'(acc_exp));
      end
    end

    // Valid held through FLUSH/DONE is not taken until IDLE.
    do_reset();
    applyStimulus(1'b1, 1'b1, slice_a(0), slice_b(0), 1'b1);
    checkOutput("bp.c1", 1'b0, 1'b1, 1'b0, 1);
    for (int c = 2; c <= 7; c++) begin
      applyStimulus(1'b1, 1'b0, slice_a(5), slice_b(5), 1'b0);
      checkOutput($sformatf("bp.c%0d", c), 1'b0, 1'b1, 1'b0, 1);
    end
    applyStimulus(1'b1, 1'b0, slice_a(5), slice_b(5), 1'b0);
    checkOutput("bp.c8", 1'b0, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, slice_a(5), slice_b(5), 1'b0);
    checkOutput("bp.c9", 1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, slice_a(5), slice_b(5), 1'b1);
    checkOutput("bp.c10", 1'b1, 1'b1, 1'b0, 1);
    compare("bp.held_beat", a_o[0], elem_a(5, 0));
    applyStimulus(1'b1, 1'b1, slice_a(6), slice_b(6), 1'b1);
    checkOutput("bp.c11", 1'b0, 1'b1, 1'b0, 2);
    for (int c = 12; c <= 17; c++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
      checkOutput($sformatf("bp.c%0d", c), 1'b0, 1'b1, 1'b0, 2);
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("bp.c18", 1'b0, 1'b0, 1'b1, 2);

    // K_MAX=2 instance takes three beats: err latches on the third.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, logic'(k == 2), slice_a(k), slice_b(k), 1'b1);
      checkOutput($sformatf("ovf.c%0d", k+1), logic'(k < 2), 1'b1, 1'b0, k+1);
      compare($sformatf("ovf.c%0d.err", k+1), err_s, logic'(k == 2));
      compare($sformatf("ovf.c%0d.k", k+1), 64'(k_cnt_s), 64'((k < 2) ? k+1 : 2));
    end
    for (int c = 4; c <= 9; c++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
      checkOutput($sformatf("ovf.c%0d", c), 1'b0, 1'b1, 1'b0, 3);
      compare($sformatf("ovf.c%0d.err", c), err_s, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("ovf.c10", 1'b0, 1'b0, 1'b1, 3);
    compare("ovf.c10.done_small", done_s, 1'b1);
    compare("ovf.c10.err", err_s, 1'b1);
    compare("ovf.c10.k", 64'(k_cnt_s), 64'(2));
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    compare("ovf.c11.err_sticky", err_s, 1'b1);
    compare("ovf.c11.k_cleared", 64'(k_cnt_s), 64'(0));

    // Reset mid-STREAM: outputs clear without a clock edge and no done follows.
    applyStimulus(1'b1, 1'b0, slice_a(7), slice_b(7), 1'b1);
    checkOutput("rst.s1", 1'b1, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, slice_a(8), slice_b(8), 1'b1);
    checkOutput("rst.s2", 1'b1, 1'b1, 1'b0, 2);
    rst_i = 1'b0;
    valid_i = 1'b0;
    #1;
    compare("rst.async.a_o", a_o, '0);
    compare("rst.async.b_o", b_o, '0);
    compare("rst.async.k_cnt_o", 64'(k_cnt_o), 64'(0));
    compare("rst.async.busy_o", busy_o, 1'b0);
    compare("rst.async.ready_o", ready_o, 1'b1);
    compare("rst.async.err_small", err_s, 1'b0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
      checkOutput($sformatf("rst.after%0d", c), 1'b1, 1'b0, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
